// File: rtl/maj_pipe_adder.sv
// Pipelined majority-gate ripple-carry adder/subtractor with valid/ready handshake.
// Carry chain is cut into zones of BITS_PER_STAGE cells; operands skew in, sums deskew out.
module maj_pipe_adder #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = (WIDTH + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
    localparam int unsigned LAST   = STAGES - 1;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic maj5(input logic x, input logic y, input logic z,
                                  input logic u, input logic w);
        logic [2:0] n;
        n = 3'(x) + 3'(y) + 3'(z) + 3'(u) + 3'(w);
        return n >= 3'd3;
    endfunction

    // Per-stage registers: skewed operands, partial sum, zone carry, valid.
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];
    logic             ovf_r;

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];
    logic [WIDTH-1:0] nx_s  [STAGES];
    logic             nx_c  [STAGES];
    logic             nx_ovf;
    logic             stall;

    assign stall     = st_v[LAST] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = st_v[LAST];
    assign sum       = st_s[LAST];
    assign cout      = st_c[LAST];
    assign ovf       = ovf_r;

    // Stage inputs and majority-cell zone evaluation.
    always_comb begin
        logic carry;
        logic cn;
        carry    = 1'b0;
        cn       = 1'b0;
        nx_ovf   = 1'b0;
        src_a[0] = a;
        src_b[0] = b ^ {WIDTH{sub}};
        src_c[0] = sub | cin;
        src_s[0] = '0;
        src_v[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_a[k] = st_a[k-1];
            src_b[k] = st_b[k-1];
            src_c[k] = st_c[k-1];
            src_s[k] = st_s[k-1];
            src_v[k] = st_v[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            carry   = src_c[k];
            nx_s[k] = src_s[k];
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i / BITS_PER_STAGE == k) begin
                    cn         = maj3(src_a[k][i], src_b[k][i], carry);
                    nx_s[k][i] = maj5(src_a[k][i], src_b[k][i], carry, ~cn, ~cn);
                    if (i == WIDTH - 1) begin
                        nx_ovf = carry ^ cn;
                    end
                    carry = cn;
                end
            end
            nx_c[k] = carry;
        end
    end

    // Pipeline advance; the output stage only updates its payload on a valid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_a[k] <= '0;
                st_b[k] <= '0;
                st_s[k] <= '0;
                st_c[k] <= 1'b0;
                st_v[k] <= 1'b0;
            end
            ovf_r <= 1'b0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_v[k] <= src_v[k];
                if (k != LAST || src_v[k]) begin
                    st_a[k] <= src_a[k];
                    st_b[k] <= src_b[k];
                    st_s[k] <= nx_s[k];
                    st_c[k] <= nx_c[k];
                end
            end
            if (src_v[LAST]) begin
                ovf_r <= nx_ovf;
            end
        end
    end

endmodule

// File: tb/tb_maj_pipe_adder.sv
// Self-checking bench: an 8-bit/2-bit-zone adder and a 4-bit/3-bit-zone adder run side by side
// against an arithmetic reference with per-operation latency tracking.
module tb_maj_pipe_adder;

    localparam int unsigned W0 = 8;
    localparam int unsigned P0 = 2;
    localparam int unsigned W1 = 4;
    localparam int unsigned P1 = 3;
    localparam int unsigned S0 = (W0 + P0 - 1) / P0;
    localparam int unsigned S1 = (W1 + P1 - 1) / P1;

    typedef struct {
        logic [9:0]  r;
        int unsigned st;
    } ent_t;

    logic       clk;
    logic       rst;
    logic       iv [2];
    logic       out_ready;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic       cin_r;
    logic       sub_r;
    logic       ov_x [2];
    logic       ir_x [2];
    logic       co_x [2];
    logic       of_x [2];
    logic [7:0] sum8;
    logic [3:0] sum4;

    int         tests;
    int         errors;
    int unsigned act [2];
    logic [9:0] last [2];
    logic       accepted [2];
    int         hold;
    ent_t       q0 [$];
    ent_t       q1 [$];

    maj_pipe_adder #(.WIDTH(W0), .BITS_PER_STAGE(P0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir_x[0]),
        .a(a_r), .b(b_r), .cin(cin_r), .sub(sub_r),
        .out_valid(ov_x[0]), .out_ready(out_ready),
        .sum(sum8), .cout(co_x[0]), .ovf(of_x[0])
    );

    maj_pipe_adder #(.WIDTH(W1), .BITS_PER_STAGE(P1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir_x[1]),
        .a(a_r[3:0]), .b(b_r[3:0]), .cin(cin_r), .sub(sub_r),
        .out_valid(ov_x[1]), .out_ready(out_ready),
        .sum(sum4), .cout(co_x[1]), .ovf(of_x[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic on a w-bit datapath.
    function automatic logic [9:0] calc(input int unsigned w, input logic [7:0] av,
                                        input logic [7:0] bv, input logic ci, input logic sb);
        int unsigned m, x, y, t, s, sa, sy, ss;
        logic [7:0] bb;
        m  = (32'd1 << w) - 32'd1;
        bb = sb ? ~bv : bv;
        x  = 32'(av) & m;
        y  = 32'(bb) & m;
        t  = x + y + (sb ? 32'd1 : 32'(ci));
        s  = t & m;
        sa = (x >> (w - 1)) & 32'd1;
        sy = (y >> (w - 1)) & 32'd1;
        ss = (s >> (w - 1)) & 32'd1;
        return {(sa == sy) && (ss != sa), ((t >> w) & 32'd1) != 0, 8'(s)};
    endfunction

    // One clock: check outputs at negedge+1 against the model, then apply transfers at the edge.
    task automatic tick();
        logic [7:0] sm [2];
        ent_t       fr [2];
        logic       has [2];
        logic       ev [2];
        logic       stl [2];
        logic       fire [2];
        logic       pop [2];
        ent_t       ne;
        #1;
        sm[0]  = sum8;
        sm[1]  = {4'b0, sum4};
        has[0] = q0.size() > 0;
        has[1] = q1.size() > 0;
        fr[0]  = has[0] ? q0[0] : '{r: 10'b0, st: 0};
        fr[1]  = has[1] ? q1[0] : '{r: 10'b0, st: 0};
        for (int d = 0; d < 2; d++) begin
            ev[d]   = has[d] && (act[d] - fr[d].st >= ((d == 0) ? S0 : S1));
            stl[d]  = ev[d] && !out_ready;
            check(d == 0 ? "out_valid8" : "out_valid4", 32'(ov_x[d]), 32'(ev[d]));
            check(d == 0 ? "in_ready8" : "in_ready4", 32'(ir_x[d]), 32'(!stl[d]));
            if (ev[d]) begin
                check(d == 0 ? "sum8" : "sum4", 32'(sm[d]), 32'(fr[d].r[7:0]));
                check(d == 0 ? "cout8" : "cout4", 32'(co_x[d]), 32'(fr[d].r[8]));
                check(d == 0 ? "ovf8" : "ovf4", 32'(of_x[d]), 32'(fr[d].r[9]));
            end else begin
                check(d == 0 ? "hold8" : "hold4", 32'({of_x[d], co_x[d], sm[d]}), 32'(last[d]));
            end
            pop[d]  = ev[d] && out_ready;
            fire[d] = iv[d] && !stl[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            accepted[d] = fire[d];
            if (!stl[d]) begin
                if (pop[d]) begin
                    last[d] = fr[d].r;
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
                if (fire[d]) begin
                    ne.r  = calc((d == 0) ? W0 : W1, a_r, b_r, cin_r, sub_r);
                    ne.st = act[d];
                    if (d == 0) q0.push_back(ne);
                    else        q1.push_back(ne);
                end
                act[d]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        #1;
        check("rst_valid8", 32'(ov_x[0]), 32'd0);
        check("rst_valid4", 32'(ov_x[1]), 32'd0);
        check("rst_out8", 32'({of_x[0], co_x[0], sum8}), 32'd0);
        check("rst_out4", 32'({of_x[1], co_x[1], sum4}), 32'd0);
        check("rst_ready8", 32'(ir_x[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold8", 32'({ov_x[0], of_x[0], co_x[0], sum8}), 32'd0);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        last[0] = '0;
        last[1] = '0;
    endtask

    task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                      input logic sb, input bit rnd);
        int n;
        a_r   = av;
        b_r   = bv;
        cin_r = ci;
        sub_r = sb;
        iv[0] = 1'b1;
        iv[1] = 1'b1;
        n     = 0;
        while ((iv[0] || iv[1]) && n < 64) begin
            if (hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            tick();
            if (accepted[0]) iv[0] = 1'b0;
            if (accepted[1]) iv[1] = 1'b0;
            n++;
        end
        if (iv[0] || iv[1]) begin
            tests++;
            errors++;
            $display("FAIL accept_timeout: operand not taken after %0d cycles", n);
            iv[0] = 1'b0;
            iv[1] = 1'b0;
        end
    endtask

    task automatic idle(input int n, input bit rnd);
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        for (int i = 0; i < n; i++) begin
            out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            tick();
        end
    endtask

    initial begin
        tests     = 0;
        errors    = 0;
        hold      = 0;
        act[0]    = 0;
        act[1]    = 0;
        rst       = 1'b1;
        iv[0]     = 1'b0;
        iv[1]     = 1'b0;
        out_ready = 1'b1;
        a_r       = '0;
        b_r       = '0;
        cin_r     = 1'b0;
        sub_r     = 1'b0;
        @(negedge clk);
        do_reset();

        op(8'h00, 8'h00, 1'b0, 1'b0, 0);
        idle(6, 0);

        op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        op(8'h12, 8'h34, 1'b1, 1'b0, 0);
        idle(6, 0);

        op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        op(8'h80, 8'h01, 1'b1, 1'b1, 0);
        idle(6, 0);

        // Six-op stream with a three-cycle downstream stall once results start emerging.
        for (int i = 0; i < 6; i++) begin
            if (i == 4) hold = 3;
            op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        idle(8, 0);

        // Reset with operations in flight; none of them may surface.
        for (int i = 0; i < 3; i++) begin
            op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0);
        end
        do_reset();
        op(8'h3C, 8'h0F, 1'b1, 1'b0, 0);
        idle(6, 0);

        // Every 4-bit operand pair in every cin/sub mode, random backpressure.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int m = 0; m < 4; m++) begin
                    op({4'($urandom_range(0, 15)), 4'(ai)},
                       {4'($urandom_range(0, 15)), 4'(bi)},
                       1'(m), 1'(m >> 1), 1);
                end
            end
        end
        idle(6, 0);

        // Random traffic with bubbles and backpressure.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1, 1);
            else op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1);
        end
        idle(10, 0);

        check("drain8", 32'(q0.size()), 32'd0);
        check("drain4", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
